clk_tick_receiver: RTL and testbench

Receiving end of the divided-clock level produced by the system clock divider. Synchronizes the slow level into the `clk` domain and converts each rising edge into a one-cycle enable pulse for downstream logic. Measures the edge-to-edge period and reports lock/loss. Sits between the divider and every consumer that previously used the divided signal as a clock, so all logic stays on the single `clk`.

---
 rtl/clk_tick_receiver_pkg.sv | 18 +
 rtl/clk_tick_receiver_if.sv | 22 ++
 rtl/tick_sync_edge.sv | 24 ++
 rtl/clk_tick_receiver.sv | 139 +++++++++++++
 tb/tb_clk_tick_receiver.sv | 240 ++++++++++++++++++++++++
 5 files changed

// File: rtl/clk_tick_receiver_pkg.sv
// Shared definitions for the divided-clock tick receiver and the divider feeding it.
package clk_tick_receiver_pkg;

   // Receiver states; the encoding is relied on by anything that peeks at the state register.
   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_ACQUIRE = 2'd1,
      ST_LOCKED  = 2'd2,
      ST_LOST    = 2'd3
   } tick_state_e;

   // Divider and receiver defaults kept together so both ends agree on the tick rate.
   localparam int DIV_PERIOD      = 10000001;
   localparam int TICK_TIMEOUT    = 12000000;
   localparam int TICK_LOCK_EDGES = 3;
   localparam int TICK_CNT_W      = 24;

endpackage

// File: rtl/clk_tick_receiver_if.sv
// Control and status bundle between the tick receiver and whoever owns it.
interface clk_tick_receiver_if #(
   parameter int CNT_W = clk_tick_receiver_pkg::TICK_CNT_W
);
   logic             en;
   logic             tick_in;
   logic             clr;
   logic             tick_pulse;
   logic [CNT_W-1:0] period;
   logic             locked;
   logic             lost;

   modport master (
      output en, tick_in, clr,
      input  tick_pulse, period, locked, lost
   );

   modport slave (
      input  en, tick_in, clr,
      output tick_pulse, period, locked, lost
   );
endinterface

// File: rtl/tick_sync_edge.sv
// Three-flop synchronizer with rising-edge detect for a slow asynchronous level.
module tick_sync_edge (
   input  logic clk,
   input  logic rst_n,
   input  logic level_i,
   output logic rise_o
);
   logic [2:0] sync_q;
   logic [2:0] armed_q;

   // Shift the level through three flops; armed_q marks when sync_q[2] holds a real sample,
   // so a level that is already high when reset releases is not mistaken for an edge.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sync_q  <= '0;
         armed_q <= '0;
      end else begin
         sync_q  <= {sync_q[1:0], level_i};
         armed_q <= {armed_q[1:0], 1'b1};
      end
   end

   assign rise_o = sync_q[1] & ~sync_q[2] & armed_q[2];
endmodule

// File: rtl/clk_tick_receiver.sv
// Turns the divided-clock level into single-cycle enables on clk and tracks its period and lock.
module clk_tick_receiver
   import clk_tick_receiver_pkg::*;
#(
   parameter int CNT_W      = TICK_CNT_W,
   parameter int TIMEOUT    = TICK_TIMEOUT,
   parameter int LOCK_EDGES = TICK_LOCK_EDGES
) (
   input logic                clk,
   input logic                rst_n,
   clk_tick_receiver_if.slave bus
);
   localparam int               EW           = $clog2(LOCK_EDGES + 1);
   localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(TIMEOUT - 1);
   localparam logic [EW-1:0]    LOCK_LAST    = EW'(LOCK_EDGES - 1);

   tick_state_e      state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d, cntInc;
   logic [EW-1:0]    edgeCnt_q, edgeCnt_d;
   logic             prevEdge_q, prevEdge_d;
   logic [CNT_W-1:0] period_q, period_d;
   logic             tickPulse_q, tickPulse_d;
   logic             locked_q;
   logic             lost_q, lost_d;
   logic             rise;
   logic             timeoutHit;
   logic             enterLost;

   tick_sync_edge uSync (
      .clk     (clk),
      .rst_n   (rst_n),
      .level_i (bus.tick_in),
      .rise_o  (rise)
   );

   assign cntInc     = (cnt_q == '1) ? cnt_q : cnt_q + CNT_W'(1);
   assign timeoutHit = (cnt_q == TIMEOUT_LAST);

   // Next-state and datapath decisions; an edge always beats a timeout in the same cycle.
   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      edgeCnt_d   = edgeCnt_q;
      prevEdge_d  = prevEdge_q;
      period_d    = period_q;
      tickPulse_d = 1'b0;
      enterLost   = 1'b0;

      if (!bus.en) begin
         state_d = ST_IDLE;
      end else begin
         case (state_q)
            ST_IDLE: begin
               state_d    = ST_ACQUIRE;
               cnt_d      = '0;
               edgeCnt_d  = '0;
               prevEdge_d = 1'b0;
            end
            ST_ACQUIRE: begin
               if (rise) begin
                  tickPulse_d = 1'b1;
                  cnt_d       = '0;
                  prevEdge_d  = 1'b1;
                  edgeCnt_d   = edgeCnt_q + EW'(1);
                  if (prevEdge_q) period_d = cntInc;
                  if (edgeCnt_q == LOCK_LAST) state_d = ST_LOCKED;
               end else begin
                  cnt_d = cntInc;
                  if (timeoutHit) begin
                     state_d   = ST_LOST;
                     enterLost = 1'b1;
                  end
               end
            end
            ST_LOCKED: begin
               if (rise) begin
                  tickPulse_d = 1'b1;
                  cnt_d       = '0;
                  period_d    = cntInc;
               end else begin
                  cnt_d = cntInc;
                  if (timeoutHit) begin
                     state_d   = ST_LOST;
                     enterLost = 1'b1;
                  end
               end
            end
            ST_LOST: begin
               if (rise) begin
                  tickPulse_d = 1'b1;
                  cnt_d       = '0;
                  edgeCnt_d   = EW'(1);
                  prevEdge_d  = 1'b1;
                  state_d     = ST_ACQUIRE;
               end else begin
                  cnt_d = cntInc;
               end
            end
            default: state_d = ST_IDLE;
         endcase
      end

      lost_d = lost_q;
      if (enterLost)    lost_d = 1'b1;
      else if (bus.clr) lost_d = 1'b0;
   end

   // State register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state_q <= ST_IDLE;
      else        state_q <= state_d;
   end

   // Counters and registered outputs; locked is registered off the next state so it tracks LOCKED.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_q       <= '0;
         edgeCnt_q   <= '0;
         prevEdge_q  <= 1'b0;
         period_q    <= '0;
         tickPulse_q <= 1'b0;
         locked_q    <= 1'b0;
         lost_q      <= 1'b0;
      end else begin
         cnt_q       <= cnt_d;
         edgeCnt_q   <= edgeCnt_d;
         prevEdge_q  <= prevEdge_d;
         period_q    <= period_d;
         tickPulse_q <= tickPulse_d;
         locked_q    <= (state_d == ST_LOCKED);
         lost_q      <= lost_d;
      end
   end

   assign bus.tick_pulse = tickPulse_q;
   assign bus.period     = period_q;
   assign bus.locked     = locked_q;
   assign bus.lost       = lost_q;
endmodule

// File: tb/tb_clk_tick_receiver.sv
// Directed bench for the tick receiver with a small TIMEOUT so loss and lock happen quickly.
module tb_clk_tick_receiver;
   localparam int CNT_W      = 8;
   localparam int TIMEOUT    = 40;
   localparam int LOCK_EDGES = 3;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   int   total = 0;
   int   bad = 0;
   int   cyc = 0;
   int   rise0;
   int   lastP;
   logic seen;

   int pulseCyc[$];
   int pulsePer[$];
   int pulseLock[$];

   clk_tick_receiver_if #(.CNT_W(CNT_W)) bus ();

   clk_tick_receiver #(
      .CNT_W      (CNT_W),
      .TIMEOUT    (TIMEOUT),
      .LOCK_EDGES (LOCK_EDGES)
   ) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   // 100 MHz clock.
   always #5 clk = ~clk;

   // Free-running cycle number, advanced on every rising edge.
   always @(posedge clk) cyc <= cyc + 1;

   // Log every cycle in which a pulse is visible, with the status seen alongside it.
   always @(negedge clk) begin
      if (bus.tick_pulse) begin
         pulseCyc.push_back(cyc);
         pulsePer.push_back(int'(bus.period));
         pulseLock.push_back(int'(bus.locked));
      end
   end

   // Hard stop in case something stalls the main sequence.
   initial begin
      #2000000;
      $display("[TB] FAIL watchdog: got timeout, want finish");
      $fatal(1, "[TB] watchdog expired");
   end

   task automatic checkOutput(input string tag, input int actual, input int expected);
      total++;
      if (actual !== expected) begin
         bad++;
         $display("[TB] FAIL %s: got %0d, want %0d", tag, actual, expected);
      end
   endtask

   task automatic applyStimulus(input logic level, input int cycles);
      bus.tick_in = level;
      repeat (cycles) @(negedge clk);
   endtask

   task automatic applySquare(input int half, input int edges, output int firstRise);
      firstRise = -1;
      for (int e = 0; e < edges; e++) begin
         if (e == 0) firstRise = cyc;
         applyStimulus(1'b1, half);
         applyStimulus(1'b0, half);
      end
   endtask

   task automatic clearLog();
      pulseCyc.delete();
      pulsePer.delete();
      pulseLock.delete();
   endtask

   task automatic waitUntilCyc(input int target, input string tag);
      int guard = 0;
      while (cyc < target && guard < 1000) begin
         @(negedge clk);
         guard++;
      end
      checkOutput(tag, cyc, target);
   endtask

   function automatic int cycAt(input int i);
      return (i < pulseCyc.size()) ? pulseCyc[i] : -1;
   endfunction

   function automatic int perAt(input int i);
      return (i < pulsePer.size()) ? pulsePer[i] : -1;
   endfunction

   function automatic int lockAt(input int i);
      return (i < pulseLock.size()) ? pulseLock[i] : -1;
   endfunction

   initial begin
      bus.en      = 1'b0;
      bus.tick_in = 1'b0;
      bus.clr     = 1'b0;
      rst_n       = 1'b0;
      repeat (3) @(negedge clk);

      // Reset state
      checkOutput("rst_pulse", int'(bus.tick_pulse), 0);
      checkOutput("rst_period", int'(bus.period), 0);
      checkOutput("rst_locked", int'(bus.locked), 0);
      checkOutput("rst_lost", int'(bus.lost), 0);

      rst_n = 1'b1;
      @(negedge clk);
      bus.en = 1'b1;
      repeat (5) @(negedge clk);

      // Acquire and lock on a period-20 square wave
      clearLog();
      applySquare(10, 4, rise0);
      checkOutput("t1_count", pulseCyc.size(), 4);
      checkOutput("t1_latency", cycAt(0), rise0 + 3);
      checkOutput("t1_gap01", cycAt(1) - cycAt(0), 20);
      checkOutput("t1_gap12", cycAt(2) - cycAt(1), 20);
      checkOutput("t1_gap23", cycAt(3) - cycAt(2), 20);
      checkOutput("t1_per0", perAt(0), 0);
      checkOutput("t1_per1", perAt(1), 20);
      checkOutput("t1_per2", perAt(2), 20);
      checkOutput("t1_lock1", lockAt(1), 0);
      checkOutput("t1_lock2", lockAt(2), 1);
      checkOutput("t1_lock3", lockAt(3), 1);

      // Tick stops: loss exactly TIMEOUT cycles after the last pulse edge
      lastP = cycAt(3);
      waitUntilCyc(lastP + TIMEOUT - 1, "t2_wait");
      checkOutput("t2_lost_before", int'(bus.lost), 0);
      checkOutput("t2_locked_before", int'(bus.locked), 1);
      @(negedge clk);
      checkOutput("t2_lost_at", int'(bus.lost), 1);
      checkOutput("t2_locked_at", int'(bus.locked), 0);

      // Recovery from LOST: first edge does not update period, two more edges relock
      clearLog();
      applySquare(10, 3, rise0);
      checkOutput("t2_count", pulseCyc.size(), 3);
      checkOutput("t2_latency", cycAt(0), rise0 + 3);
      checkOutput("t2_per0", perAt(0), 20);
      checkOutput("t2_per1", perAt(1), 20);
      checkOutput("t2_lock0", lockAt(0), 0);
      checkOutput("t2_lock1", lockAt(1), 0);
      checkOutput("t2_lock2", lockAt(2), 1);
      checkOutput("t2_lost_sticky", int'(bus.lost), 1);

      // clr clears lost on the next cycle
      bus.clr = 1'b1;
      @(negedge clk);
      bus.clr = 1'b0;
      checkOutput("t3_clr", int'(bus.lost), 0);

      // clr during the timeout cycle: set wins
      lastP = cycAt(2);
      waitUntilCyc(lastP + TIMEOUT - 1, "t3_wait");
      checkOutput("t3_locked_before", int'(bus.locked), 1);
      bus.clr = 1'b1;
      @(negedge clk);
      bus.clr = 1'b0;
      checkOutput("t3_set_wins", int'(bus.lost), 1);
      checkOutput("t3_locked_at", int'(bus.locked), 0);

      // Edges landing exactly on the timeout cycle (period 40)
      bus.clr = 1'b1;
      @(negedge clk);
      bus.clr = 1'b0;
      checkOutput("t4_clr", int'(bus.lost), 0);
      clearLog();
      applySquare(20, 4, rise0);
      checkOutput("t4_count", pulseCyc.size(), 4);
      checkOutput("t4_gap01", cycAt(1) - cycAt(0), 40);
      checkOutput("t4_gap23", cycAt(3) - cycAt(2), 40);
      checkOutput("t4_per0", perAt(0), 20);
      checkOutput("t4_per1", perAt(1), 40);
      checkOutput("t4_per3", perAt(3), 40);
      checkOutput("t4_lock2", lockAt(2), 1);
      checkOutput("t4_lost", int'(bus.lost), 0);
      checkOutput("t4_locked", int'(bus.locked), 1);

      // Disable mid-LOCKED: no pulses, period held, re-enable needs full acquisition
      bus.en = 1'b0;
      @(negedge clk);
      checkOutput("t5_locked_off", int'(bus.locked), 0);
      clearLog();
      applySquare(20, 2, rise0);
      checkOutput("t5_no_pulses", pulseCyc.size(), 0);
      checkOutput("t5_period_held", int'(bus.period), 40);
      checkOutput("t5_lost_held", int'(bus.lost), 0);
      bus.en = 1'b1;
      repeat (3) @(negedge clk);
      clearLog();
      applySquare(10, 3, rise0);
      checkOutput("t5_count", pulseCyc.size(), 3);
      checkOutput("t5_per0", perAt(0), 40);
      checkOutput("t5_per1", perAt(1), 20);
      checkOutput("t5_lock1", lockAt(1), 0);
      checkOutput("t5_lock2", lockAt(2), 1);

      // Asynchronous reset in the middle of a pulse, then release with tick_in high
      bus.tick_in = 1'b1;
      seen = 1'b0;
      for (int i = 0; i < 10 && !seen; i++) begin
         @(negedge clk);
         if (bus.tick_pulse) seen = 1'b1;
      end
      checkOutput("t6_pulse_seen", int'(seen), 1);
      #1 rst_n = 1'b0;
      #1;
      checkOutput("t6_rst_pulse", int'(bus.tick_pulse), 0);
      checkOutput("t6_rst_period", int'(bus.period), 0);
      checkOutput("t6_rst_locked", int'(bus.locked), 0);
      checkOutput("t6_rst_lost", int'(bus.lost), 0);
      @(negedge clk);
      @(negedge clk);
      clearLog();
      rst_n = 1'b1;
      repeat (12) @(negedge clk);
      checkOutput("t6_no_spurious", pulseCyc.size(), 0);
      checkOutput("t6_locked", int'(bus.locked), 0);
      applyStimulus(1'b0, 10);
      clearLog();
      applySquare(10, 1, rise0);
      checkOutput("t6_count", pulseCyc.size(), 1);
      checkOutput("t6_latency", cycAt(0), rise0 + 3);
      checkOutput("t6_per0", perAt(0), 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
